pakout_arbiter: RTL and testbench



---
 rtl/pakout_arbiter_pkg.sv | 9 +
 rtl/pakout_arbiter_rr_pick2.sv | 11 +
 rtl/pakout_arbiter.sv | 93 +++++++++
 tb/tb_pakout_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pakout_arbiter_pkg.sv
// pakout_arbiter_pkg: shared packet width and arbiter state encodings
package pakout_arbiter_pkg;
    localparam int NS_PACKET_SIZE = 8;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/pakout_arbiter_rr_pick2.sv
// rr_pick2: combinational two-request round-robin picker
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);
    assign gnt_valid = req0 || req1;
    assign gnt_idx   = (req0 && req1) ? !last : req1;
endmodule

// File: rtl/pakout_arbiter.sv
// pakout_arbiter: two-source round-robin arbiter onto one 4-phase packet send channel
module pakout_arbiter
    import pakout_arbiter_pkg::*;
#(
    parameter int PSZ    = NS_PACKET_SIZE,
    parameter int CNT_SZ = 8
) (
    input  logic              i_clk,
    input  logic              reset,
    output logic              ready,
    input  logic              rcv0_req,
    input  logic [PSZ-1:0]    rcv0_data,
    output logic              rcv0_ack,
    input  logic              rcv1_req,
    input  logic [PSZ-1:0]    rcv1_data,
    output logic              rcv1_ack,
    output logic              snd0_req,
    output logic [PSZ-1:0]    snd0_data,
    input  logic              snd0_ack,
    output logic [CNT_SZ-1:0] grant_cnt0,
    output logic [CNT_SZ-1:0] grant_cnt1,
    output logic              proto_err
);
    arb_state_t state;
    logic       sel;
    logic       last_grant;
    logic       gnt_valid;
    logic       gnt_idx;
    logic       sel_req;

    assign sel_req = sel ? rcv1_req : rcv0_req;

    rr_pick2 u_pick (
        .req0      (rcv0_req),
        .req1      (rcv1_req),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ready      <= 1'b0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            rcv0_ack   <= 1'b0;
            rcv1_ack   <= 1'b0;
            snd0_req   <= 1'b0;
            snd0_data  <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // a lingering downstream ack from the last packet blocks a new grant
                    if (gnt_valid && !snd0_ack) begin
                        snd0_data <= gnt_idx ? rcv1_data : rcv0_data;
                        sel       <= gnt_idx;
                        snd0_req  <= 1'b1;
                        ready     <= 1'b0;
                        state     <= ST_SEND;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!sel_req)
                        proto_err <= 1'b1;
                    if (snd0_ack) begin
                        snd0_req <= 1'b0;
                        rcv0_ack <= !sel;
                        rcv1_ack <= sel;
                        state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!sel_req && !snd0_ack) begin
                        rcv0_ack   <= 1'b0;
                        rcv1_ack   <= 1'b0;
                        last_grant <= sel;
                        grant_cnt0 <= grant_cnt0 + CNT_SZ'(!sel);
                        grant_cnt1 <= grant_cnt1 + CNT_SZ'(sel);
                        ready      <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pakout_arbiter.sv
// tb_pakout_arbiter: randomized scoreboard bench; grant order predicted from round-robin rules
module tb_pakout_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rq = 2'b00;
    logic [7:0] dt [2];
    logic       ak0, ak1;
    logic       snd_req, snd_ack = 1'b0;
    logic [7:0] snd_data;
    logic       ready, proto_err;
    logic [7:0] cnt0, cnt1;
    wire  [1:0] ak = {ak1, ak0};

    int         vec = 0, mis = 0;
    int         done [2];
    logic [7:0] q0 [$], q1 [$];
    int         order [$];
    bit         rnd = 0;
    int         fix = 2, tgt = 2, wcnt = 0;

    pakout_arbiter #(.PSZ(8), .CNT_SZ(8)) dut (
        .i_clk      (clk),
        .reset      (reset),
        .ready      (ready),
        .rcv0_req   (rq[0]),
        .rcv0_data  (dt[0]),
        .rcv0_ack   (ak0),
        .rcv1_req   (rq[1]),
        .rcv1_data  (dt[1]),
        .rcv1_ack   (ak1),
        .snd0_req   (snd_req),
        .snd0_data  (snd_data),
        .snd0_ack   (snd_ack),
        .grant_cnt0 (cnt0),
        .grant_cnt1 (cnt1),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act != exp) begin
            mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int k);
        return k == 0 ? ak0 : k == 1 ? ak1 : k == 2 ? snd_req : k == 3 ? snd_ack : ready;
    endfunction

    task automatic wait_sig(input int k, input logic v, input string nm);
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sig(k) == v) return;
        end
        vec++;
        mis++;
        $display("FAIL timeout %s: got %0b expected %0b", nm, !v, v);
    endtask

    task automatic send(input int s, input logic [7:0] d, input bit drop);
        @(posedge clk); #1;
        dt[s] = d;
        rq[s] = 1'b1;
        if (s == 0) q0.push_back(d); else q1.push_back(d);
        if (drop) begin
            wait_sig(2, 1'b1, "snd_req_rise");
            @(posedge clk); #1;
            rq[s] = 1'b0;
        end
        wait_sig(s, 1'b1, "rcv_ack_rise");
        if (!drop) begin
            @(posedge clk); #1;
            rq[s] = 1'b0;
        end
        wait_sig(s, 1'b0, "rcv_ack_fall");
        done[s]++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        rq = 2'b00;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_snd_req", snd_req, 0);
        chk("rst_snd_data", snd_data, 0);
        chk("rst_acks", ak, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_proto_err", proto_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done = '{0, 0};
        order.delete();
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
    endtask

    // downstream sink: ack after tgt cycles of req, release once req drops
    initial forever begin
        @(posedge clk); #1;
        if (snd_req && !snd_ack) begin
            if (wcnt >= tgt) begin
                snd_ack = 1'b1;
                wcnt = 0;
                tgt = rnd ? int'($urandom_range(0, 3)) : fix;
            end else wcnt++;
        end else if (!snd_req) begin
            snd_ack = 1'b0;
            wcnt = 0;
            tgt = rnd ? int'($urandom_range(0, 3)) : fix;
        end
    end

    // monitor: predicts the winner from the requests seen before the grant edge
    initial begin
        logic       last_m = 1'b1, cur = 1'b0, prev_snd = 1'b0;
        logic [1:0] snap = 2'b00;
        logic [7:0] held = '0, e;
        int         w;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_m = 1'b1;
                prev_snd = 1'b0;
            end else begin
                if (snd_req && !prev_snd) begin
                    vec++;
                    if (snap == 2'b00) begin
                        mis++;
                        $display("FAIL grant_without_req: got snd0_req=1 expected 0");
                    end else begin
                        w = (snap == 2'b11) ? int'(!last_m) : int'(snap[1]);
                        if ((w == 0 ? q0.size() : q1.size()) == 0) begin
                            mis++;
                            $display("FAIL sb_empty src%0d: got packet %0h expected none", w, snd_data);
                        end else begin
                            e = (w == 0) ? q0.pop_front() : q1.pop_front();
                            if (snd_data !== e) begin
                                mis++;
                                $display("FAIL packet src%0d: got %0h expected %0h", w, snd_data, e);
                            end
                        end
                        last_m = w[0];
                        cur = w[0];
                        held = snd_data;
                        order.push_back(w);
                    end
                end else if (snd_req) begin
                    chk("snd_data_stable", snd_data, held);
                end
                if (ak != 2'b00)
                    chk("ack_only_granted", ak, cur ? 2 : 1);
                prev_snd = snd_req;
            end
            snap = rq;
        end
    end

    initial begin
        int exp_ord [5] = '{0, 1, 0, 0, 0};
        dt[0] = '0;
        dt[1] = '0;
        done = '{0, 0};
        do_reset();
        chk("ready_idle", ready, 1);

        q0.push_back(8'h5A);
        dt[0] = 8'h5A;
        rq[0] = 1'b1;
        @(negedge clk);
        chk("t1_req_not_yet", snd_req, 0);
        @(negedge clk);
        chk("t1_req_rise", snd_req, 1);
        chk("t1_data", snd_data, 8'h5A);
        wait_sig(3, 1'b1, "t1_snd_ack");
        chk("t1_ack_before", ak0, 0);
        @(negedge clk);
        chk("t1_ack_follows", ak0, 1);
        @(posedge clk); #1;
        rq[0] = 1'b0;
        wait_sig(4, 1'b1, "t1_ready");
        chk("t1_cnt0", cnt0, 1);
        chk("t1_ak0_low", ak0, 0);

        do_reset();
        fork
            send(0, 8'h11, 0);
            send(1, 8'h22, 0);
        join
        chk("t2_n", order.size(), 2);
        if (order.size() == 2) begin
            chk("t2_first", order[0], 0);
            chk("t2_second", order[1], 1);
        end
        chk("t2_cnt0", cnt0, 1);
        chk("t2_cnt1", cnt1, 1);

        do_reset();
        fork
            for (int i = 0; i < 4; i++) send(0, 8'($urandom), 0);
            send(1, 8'($urandom), 0);
        join
        chk("t3_n", order.size(), 5);
        if (order.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), order[i], exp_ord[i]);
        chk("t3_cnt0", cnt0, 4);
        chk("t3_cnt1", cnt1, 1);

        do_reset();
        send(1, 8'h99, 1);
        chk("t4_proto_err", proto_err, 1);
        chk("t4_cnt1", cnt1, 1);
        send(0, 8'h42, 0);
        chk("t4_proto_sticky", proto_err, 1);

        fix = 20;
        q0.push_back(8'h77);
        @(posedge clk); #1;
        dt[0] = 8'h77;
        rq[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_in_send", snd_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_snd_req_clr", snd_req, 0);
        chk("t5_ack_clr", ak, 0);
        chk("t5_cnt0_clr", cnt0, 0);
        chk("t5_cnt1_clr", cnt1, 0);
        chk("t5_proto_clr", proto_err, 0);
        rq = 2'b00;
        fix = 2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done = '{0, 0};
        send(0, 8'h3C, 0);
        chk("t5_after_cnt0", cnt0, 1);

        do_reset();
        rnd = 1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(0, 8'($urandom), 0);
            end
            for (int j = 0; j < 30; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(1, 8'($urandom), 0);
            end
        join
        chk("t6_cnt0", cnt0, done[0]);
        chk("t6_cnt1", cnt1, done[1]);
        chk("t6_proto", proto_err, 0);
        chk("t6_sb_drained", q0.size() + q1.size(), 0);

        do_reset();
        rnd = 0;
        fix = 0;
        for (int i = 0; i < 255; i++) send(0, 8'(i), 0);
        chk("t7_cnt0_255", cnt0, 255);
        send(0, 8'hFF, 0);
        chk("t7_cnt0_wrap", cnt0, 0);
        chk("t7_cnt1", cnt1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
